ftdi_frame_buffer: RTL and testbench
====================================

Name: ftdi_frame_buffer

Overview:
- Ping-pong frame buffer directly downstream of the FTDI receive stage.
- Accepts 20-bit pixel words with addresses from the receiver and fills the back bank.
- Throttles the receiver through `writable`.
- Swaps banks at the display's vertical sync once a full frame has landed; the display driver reads the front bank with 1-cycle latency.

Parameters:
- ADDR_W, 14, pixel address width; bank depth = 2**ADDR_W
- DATA_W, 20, pixel word width (packed RGB from receiver)

Ports:
- clk_60  in  1  FTDI 60 MHz clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- sof  in  1  start-of-frame pulse (receiver frame-start marker)
- wr_en  in  1  pixel write strobe
- wr_addr  in  ADDR_W  pixel write address
- wr_data  in  DATA_W  pixel write data
- writable  out  1  high when back bank accepts writes
- disp_vsync  in  1  one-cycle pulse from display at frame boundary
- rd_en  in  1  display read strobe
- rd_addr  in  ADDR_W  display read address
- rd_data  out  DATA_W  front-bank read data
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- front_sel  out  1  bank currently displayed (0 = bank0)
- swap  out  1  one-cycle pulse when banks swap

Behaviour:
- Reset (async assert, sync release): state EMPTY, front_sel=0, writable=1, swap=0, rd_valid=0, rd_data=0. BRAM contents are not cleared. Reset mid-frame discards the partial frame.
- States: EMPTY, FILL, FULL.
- EMPTY:
  - wr_en without sof is ignored.
  - sof → FILL; a wr_en in the same cycle as sof is written.
- FILL:
  - wr_en writes wr_data to back bank (~front_sel) at wr_addr.
  - A write with wr_addr == 2**ADDR_W-1 → FULL.
  - sof while in FILL restarts the frame (stays FILL, partial frame aborted); addresses are owned by the upstream counter.
- FULL:
  - writable=0 (registered, low from the cycle after the last-address write).
  - wr_en is dropped with no BRAM write.
  - disp_vsync → toggle front_sel, swap=1 for one cycle, → EMPTY, writable=1 next cycle.
- disp_vsync in EMPTY or FILL: no swap; the same front frame is redisplayed.
- Last-address write and disp_vsync in the same cycle: go to FULL without swapping; the swap happens on the next vsync.
- sof and disp_vsync in the same cycle while FULL: the swap wins; sof is ignored (upstream must resend sof).
- Read path:
  - rd_data is registered from the front bank, latency 1; rd_valid = rd_en delayed 1.
  - Reads issued in the swap cycle use the old front; reads from the next cycle use the new front.
  - rd_data holds its value when rd_en=0.
- Writes never target the front bank; reads never see the back bank.
- No width conversion: DATA_W is passed through unchanged.

Optional Feature:
- Macro: FTDI_FB_STATS_EN.
- Defined: adds outputs frames_shown[15:0] (increments on swap), frames_aborted[15:0] (increments on sof in FILL) and drops[15:0] (increments on wr_en in FULL or EMPTY).
  - All three counters saturate at 0xFFFF and reset to 0.
- Undefined: none of these ports or counters exist; behaviour is otherwise identical.

Decomposition:
- Package fb_pkg: ADDR_W/DATA_W defaults, state encodings (EMPTY/FILL/FULL localparams), LAST_ADDR constant.
- Sub-module fb_bram_bank: simple dual-port RAM, one write port and one registered read port, inferred as BRAM; instantiated twice.
- Write/read muxing and the state machine live in the top module.

Test Plan:
- Reset → front_sel=0, writable=1, rd_valid=0; sof, then write addr 0..16383 with data=addr → state FULL, writable=0 on the cycle after the addr 16383 write, swap=0.
- From FULL, pulse disp_vsync → swap=1 for one cycle, front_sel=1; read addr 5 → rd_data=5 one cycle later with rd_valid=1.
- Before the first swap, bank0 preloaded with 0xAAAAA; fill back bank, then pulse vsync at addr 8000 → no swap, reads still return 0xAAAAA.
- Mid-fill at addr 100, assert sof and restart from 0 → frame completes only at the second pass of addr 16383 (FTDI_FB_STATS_EN: frames_aborted=1).
- In FULL, write addr 0 data 0x12345 → back bank unchanged after the swap cycle; with FTDI_FB_STATS_EN, drops increments by 1.
- Assert rst_n low at addr 9000 while reading → outputs return to reset values immediately; after release, sof plus a full frame behave as from power-up.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared sizing and state encoding for the FTDI ping-pong frame buffer.
// Optional statistics counters are enabled with FTDI_FB_STATS_EN.
package fb_pkg;

    localparam int unsigned FB_ADDR_W    = 14;
    localparam int unsigned FB_DATA_W    = 20;
    localparam int unsigned FB_LAST_ADDR = (1 << FB_ADDR_W) - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } fb_state_e;

endpackage

// File: rtl/ftdi_frame_buffer_if.sv
// Receiver-write / display-read bundle of the frame buffer.
// FTDI_FB_STATS_EN adds the three statistics outputs.
interface ftdi_frame_buffer_if import fb_pkg::*; #(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
);
    logic              sof;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              writable;
    logic              disp_vsync;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              front_sel;
    logic              swap;
`ifdef FTDI_FB_STATS_EN
    logic [15:0]       frames_shown;
    logic [15:0]       frames_aborted;
    logic [15:0]       drops;
`endif

    modport master (
`ifdef FTDI_FB_STATS_EN
        input  frames_shown, frames_aborted, drops,
`endif
        output sof, wr_en, wr_addr, wr_data, disp_vsync, rd_en, rd_addr,
        input  writable, rd_data, rd_valid, front_sel, swap
    );

    modport slave (
`ifdef FTDI_FB_STATS_EN
        output frames_shown, frames_aborted, drops,
`endif
        input  sof, wr_en, wr_addr, wr_data, disp_vsync, rd_en, rd_addr,
        output writable, rd_data, rd_valid, front_sel, swap
    );

endinterface

// File: rtl/fb_bram_bank.sv
// One frame bank: simple dual-port RAM with a registered read port.
// Array contents are never reset so the store maps onto block RAM.
module fb_bram_bank import fb_pkg::*; #(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Output register holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ftdi_frame_buffer.sv
// Ping-pong frame buffer behind the FTDI receiver: fills the back bank, swaps on vsync.
// Define FTDI_FB_STATS_EN for frames_shown / frames_aborted / drops counters.
module ftdi_frame_buffer import fb_pkg::*; #(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic                 clk_60,
    input  logic                 rst_n,
    ftdi_frame_buffer_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fb_state_e         r_state;
    logic              r_front_sel;
    logic              r_swap;
    logic              r_writable;
    logic              r_rd_valid;
    logic              r_rd_sel;
    logic              w_wr_ok;
    logic              w_last;
    logic [DATA_W-1:0] w_q0;
    logic [DATA_W-1:0] w_q1;

    // A write lands only while filling, or alongside the sof that starts a frame.
    assign w_wr_ok = bus.wr_en && ((r_state == FILL) || ((r_state == EMPTY) && bus.sof));
    assign w_last  = (bus.wr_addr == LAST_ADDR);

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_front_sel <= 1'b0;
            r_swap      <= 1'b0;
            r_writable  <= 1'b1;
        end else begin
            r_swap <= 1'b0;
            case (r_state)
                EMPTY: begin
                    if (bus.sof) begin
                        if (w_wr_ok && w_last) begin
                            r_state    <= FULL;
                            r_writable <= 1'b0;
                        end else begin
                            r_state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_wr_ok && w_last) begin
                        r_state    <= FULL;
                        r_writable <= 1'b0;
                    end
                end
                FULL: begin
                    if (bus.disp_vsync) begin
                        r_front_sel <= ~r_front_sel;
                        r_swap      <= 1'b1;
                        r_state     <= EMPTY;
                        r_writable  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_writable <= 1'b1;
                end
            endcase
        end
    end

    // Bank select is captured with the read so a swap-cycle read returns the old front.
    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_sel <= r_front_sel;
        end
    end

    fb_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .i_clk   (clk_60),
        .i_rst_n (rst_n),
        .i_we    (w_wr_ok && r_front_sel),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_re    (bus.rd_en && !r_front_sel),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_q0)
    );

    fb_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .i_clk   (clk_60),
        .i_rst_n (rst_n),
        .i_we    (w_wr_ok && !r_front_sel),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_re    (bus.rd_en && r_front_sel),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_q1)
    );

    assign bus.rd_data   = r_rd_sel ? w_q1 : w_q0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.writable  = r_writable;
    assign bus.front_sel = r_front_sel;
    assign bus.swap      = r_swap;

`ifdef FTDI_FB_STATS_EN
    logic [15:0] r_frames_shown;
    logic [15:0] r_frames_aborted;
    logic [15:0] r_drops;

    // Saturating event counters.
    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_shown   <= '0;
            r_frames_aborted <= '0;
            r_drops          <= '0;
        end else begin
            if ((r_state == FULL) && bus.disp_vsync && (r_frames_shown != 16'hFFFF))
                r_frames_shown <= r_frames_shown + 16'd1;
            if ((r_state == FILL) && bus.sof && (r_frames_aborted != 16'hFFFF))
                r_frames_aborted <= r_frames_aborted + 16'd1;
            if (bus.wr_en && !w_wr_ok && (r_drops != 16'hFFFF))
                r_drops <= r_drops + 16'd1;
        end
    end

    assign bus.frames_shown   = r_frames_shown;
    assign bus.frames_aborted = r_frames_aborted;
    assign bus.drops          = r_drops;
`endif

endmodule

// File: tb/tb_ftdi_frame_buffer.sv
// Scoreboard bench for ftdi_frame_buffer: reads are queued with expected data and
// checked by a monitor on rd_valid; control outputs are checked directly.
module tb_ftdi_frame_buffer;
    import fb_pkg::*;

    localparam int unsigned AW   = FB_ADDR_W;
    localparam int unsigned DW   = FB_DATA_W;
    localparam int          LAST = (1 << AW) - 1;

    logic clk_60 = 1'b0;
    logic rst_n  = 1'b0;

    always #8 clk_60 = ~clk_60;

    ftdi_frame_buffer_if bus ();

    ftdi_frame_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_60 (clk_60),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int             vectors     = 0;
    int             miscompares = 0;
    logic [DW-1:0]  sb [$];
    logic [DW-1:0]  mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Read-data monitor.
    always @(negedge clk_60) begin
        if (rst_n && bus.rd_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: got rd_valid with data %h, expected no read", bus.rd_data);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.rd_data !== mon_exp) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h, expected %h", bus.rd_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk_60);
        #1;
    endtask

    task automatic idle();
        bus.sof        = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.disp_vsync = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
    endtask

    task automatic rd(input int a, input logic [DW-1:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(a);
        sb.push_back(exp);
        cyc();
        bus.rd_en   = 1'b0;
    endtask

    // Write addresses lo..hi with data (addr & mask) ^ key; optionally read the front bank alongside.
    task automatic fill(input int lo, input int hi, input logic with_sof,
                        input logic [DW-1:0] mask, input logic [DW-1:0] key,
                        input logic do_rd, input logic [DW-1:0] rd_exp);
        for (int a = lo; a <= hi; a++) begin
            bus.sof     = with_sof && (a == lo);
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = (DW'(a) & mask) ^ key;
            bus.rd_en   = do_rd;
            bus.rd_addr = AW'(a);
            if (do_rd) sb.push_back(rd_exp);
            cyc();
        end
        idle();
    endtask

    initial begin
        logic [DW-1:0] all1;
        all1 = '1;
        idle();
        #20;
        chk("reset_writable",  32'(bus.writable),  32'd1);
        chk("reset_front_sel", 32'(bus.front_sel), 32'd0);
        chk("reset_swap",      32'(bus.swap),      32'd0);
        chk("reset_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("reset_rd_data",   32'(bus.rd_data),   32'd0);
        @(negedge clk_60);
        rst_n = 1'b1;
        cyc();

        // Write at the last address without sof must be ignored in EMPTY.
        bus.wr_en = 1'b1; bus.wr_addr = AW'(LAST);
        cyc(); idle();
        chk("empty_wr_ignored", 32'(bus.writable), 32'd1);

        // Frame 1 into bank1, data = addr.
        fill(0, LAST - 1, 1'b1, all1, '0, 1'b0, '0);
        chk("f1_not_full_yet", 32'(bus.writable), 32'd1);
        fill(LAST, LAST, 1'b0, all1, '0, 1'b0, '0);
        chk("f1_full_writable", 32'(bus.writable),  32'd0);
        chk("f1_full_no_swap",  32'(bus.swap),      32'd0);
        chk("f1_full_front",    32'(bus.front_sel), 32'd0);

        // Dropped write while FULL.
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = DW'(20'h12345);
        cyc(); idle();
        chk("full_drop_writable", 32'(bus.writable), 32'd0);
`ifdef FTDI_FB_STATS_EN
        chk("stats_drops_2", 32'(bus.drops), 32'd2);
`endif

        bus.disp_vsync = 1'b1;
        cyc(); idle();
        chk("swap1_pulse",    32'(bus.swap),      32'd1);
        chk("swap1_front",    32'(bus.front_sel), 32'd1);
        chk("swap1_writable", 32'(bus.writable),  32'd1);
`ifdef FTDI_FB_STATS_EN
        chk("stats_shown_1", 32'(bus.frames_shown), 32'd1);
`endif
        cyc();
        chk("swap1_one_cycle", 32'(bus.swap), 32'd0);
        rd(5, DW'(5));
        rd(0, DW'(0));
        rd(LAST, DW'(LAST));

        // Frame 2 into bank0 (0xAAAAA), aborted at 100 and restarted.
        fill(0, 100, 1'b1, '0, DW'(20'hAAAAA), 1'b0, '0);
        fill(0, 7999, 1'b1, '0, DW'(20'hAAAAA), 1'b0, '0);
`ifdef FTDI_FB_STATS_EN
        chk("stats_aborted_1", 32'(bus.frames_aborted), 32'd1);
`endif
        bus.disp_vsync = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = AW'(8000); bus.wr_data = DW'(20'hAAAAA);
        cyc(); idle();
        chk("fill_vsync_no_swap", 32'(bus.swap),      32'd0);
        chk("fill_vsync_front",   32'(bus.front_sel), 32'd1);
        rd(5, DW'(5));
        fill(8001, LAST - 1, 1'b0, '0, DW'(20'hAAAAA), 1'b0, '0);
        chk("f2_not_full_yet", 32'(bus.writable), 32'd1);
        fill(LAST, LAST, 1'b0, '0, DW'(20'hAAAAA), 1'b0, '0);
        chk("f2_full_writable", 32'(bus.writable), 32'd0);

        // sof + vsync in FULL: swap wins; swap-cycle read sees old front.
        bus.sof = 1'b1; bus.disp_vsync = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = AW'(7);
        sb.push_back(DW'(7));
        cyc(); idle();
        chk("swap2_pulse",    32'(bus.swap),      32'd1);
        chk("swap2_front",    32'(bus.front_sel), 32'd0);
        chk("swap2_writable", 32'(bus.writable),  32'd1);
        rd(7, DW'(20'hAAAAA));
        rd(LAST, DW'(20'hAAAAA));
        bus.wr_en = 1'b1; bus.wr_addr = AW'(LAST);
        cyc(); idle();
        chk("sof_ignored_on_swap", 32'(bus.writable), 32'd1);
`ifdef FTDI_FB_STATS_EN
        chk("stats_drops_3", 32'(bus.drops), 32'd3);
`endif

        // Frame 3 with concurrent front reads, reset at address 9000.
        fill(0, 9000, 1'b1, '0, DW'(20'h11111), 1'b1, DW'(20'hAAAAA));
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("midreset_rd_data",   32'(bus.rd_data),   32'd0);
        chk("midreset_front_sel", 32'(bus.front_sel), 32'd0);
        chk("midreset_writable",  32'(bus.writable),  32'd1);
        chk("midreset_swap",      32'(bus.swap),      32'd0);
`ifdef FTDI_FB_STATS_EN
        chk("midreset_shown",   32'(bus.frames_shown),   32'd0);
        chk("midreset_aborted", 32'(bus.frames_aborted), 32'd0);
        chk("midreset_drops",   32'(bus.drops),          32'd0);
`endif
        @(negedge clk_60);
        rst_n = 1'b1;
        cyc();

        // Frame 4 from power-up state; last write coincides with vsync.
        bus.wr_en = 1'b1; bus.wr_addr = AW'(LAST);
        cyc(); idle();
        chk("pu_empty_wr_ignored", 32'(bus.writable), 32'd1);
        fill(0, LAST - 1, 1'b1, all1, DW'(20'h5A5A5), 1'b0, '0);
        chk("f4_not_full_yet", 32'(bus.writable), 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(LAST); bus.wr_data = DW'(LAST) ^ DW'(20'h5A5A5);
        bus.disp_vsync = 1'b1;
        cyc(); idle();
        chk("last_vsync_writable", 32'(bus.writable),  32'd0);
        chk("last_vsync_no_swap",  32'(bus.swap),      32'd0);
        chk("last_vsync_front",    32'(bus.front_sel), 32'd0);
        bus.disp_vsync = 1'b1;
        cyc(); idle();
        chk("swap3_pulse", 32'(bus.swap),      32'd1);
        chk("swap3_front", 32'(bus.front_sel), 32'd1);
        rd(0, DW'(20'h5A5A5));
        rd(9000, DW'(9000) ^ DW'(20'h5A5A5));
        rd(LAST, DW'(LAST) ^ DW'(20'h5A5A5));
        cyc();
        chk("rd_hold_data",  32'(bus.rd_data),  32'(DW'(LAST) ^ DW'(20'h5A5A5)));
        chk("rd_hold_valid", 32'(bus.rd_valid), 32'd0);

        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
